// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode encoding and legality check.
// Used by the alu, the arbiter top and its optional ALU_OPCODE_CHECK_EN decode.
package alu_ctrl_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_LTU = 4'b0110,
        ALU_GEU = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_NE  = 4'b1001,
        ALU_SUB = 4'b1010,
        ALU_ADD = 4'b1011,
        ALU_SLT = 4'b1100,
        ALU_SRA = 4'b1101
    } alu_op_e;

    // Encodings 0010, 1110 and 1111 are holes in the opcode map.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return !((op == 4'b0010) || (op == 4'b1110) || (op == 4'b1111));
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared ALU: per-requester valid/ready request
// channel and a shared result slot with per-requester valid/ready.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_b;
    logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [NUM_REQ-1:0]               rsp_ready;
    logic [DATA_WIDTH-1:0]            rsp_result;
    logic                             rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU; unimplemented opcodes produce zero.
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    src_a,
    input  logic [DATA_WIDTH-1:0]    src_b,
    input  logic [OPCODE_LENGTH-1:0] operation,
    output logic [DATA_WIDTH-1:0]    alu_result
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic [SH_W-1:0]              shamt;

    assign a_s   = src_a;
    assign b_s   = src_b;
    assign shamt = src_b[SH_W-1:0];

    always_comb begin
        alu_result = '0;
        case (operation)
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLL: alu_result = src_a << shamt;
            ALU_SRL: alu_result = src_a >> shamt;
            ALU_LTU: alu_result = DATA_WIDTH'(src_a < src_b);
            ALU_GEU: alu_result = DATA_WIDTH'(src_a >= src_b);
            ALU_EQ:  alu_result = DATA_WIDTH'(src_a == src_b);
            ALU_NE:  alu_result = DATA_WIDTH'(src_a != src_b);
            ALU_SUB: alu_result = src_a - src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SLT: alu_result = DATA_WIDTH'(a_s < b_s);
            ALU_SRA: alu_result = a_s >>> shamt;
            default: alu_result = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping); the pointer moves past the winner when advance is set.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;

    // Scan from the farthest candidate back to the pointer so the nearest wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant and a single
// registered result slot. Optional macro ALU_OPCODE_CHECK_EN adds rsp_err.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]               state_p1;
    logic                     vld_p1;
    logic [PTR_W-1:0]         owner_p1;
    logic [DATA_WIDTH-1:0]    result_p1;

    logic [NUM_REQ-1:0]       grant;
    logic [PTR_W-1:0]         grant_idx;
    logic [DATA_WIDTH-1:0]    a_p0;
    logic [DATA_WIDTH-1:0]    b_p0;
    logic [OPCODE_LENGTH-1:0] op_p0;
    logic [DATA_WIDTH-1:0]    result_p0;
    logic                     drain;
    logic                     can_accept;
    logic                     accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // ---- p0: granted requester's operands straight into the ALU ----
    always_comb begin
        a_p0  = '0;
        b_p0  = '0;
        op_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_p0  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_p0  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                op_p0 = bus.req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
            end
        end
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .src_a      (a_p0),
        .src_b      (b_p0),
        .operation  (op_p0),
        .alu_result (result_p0)
    );

    // Slot may refill in the same cycle it drains; rsp_ready of non-owners is ignored.
    assign drain      = (state_p1 == ST_FULL) && bus.rsp_ready[owner_p1];
    assign can_accept = rst_n && ((state_p1 == ST_EMPTY) || drain);
    assign accept     = can_accept && (|grant);

    assign bus.req_ready = grant & {NUM_REQ{can_accept}};

    // ---- p1: result slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1  <= ST_EMPTY;
            owner_p1  <= '0;
            result_p1 <= '0;
        end else if (accept) begin
            state_p1  <= ST_FULL;
            owner_p1  <= grant_idx;
            result_p1 <= result_p0;
        end else if (drain) begin
            state_p1  <= ST_EMPTY;
        end
    end

    assign vld_p1 = (state_p1 == ST_FULL);

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = vld_p1 && (owner_p1 == PTR_W'(i));
        end
    end

    assign bus.rsp_result = result_p1;

`ifdef ALU_OPCODE_CHECK_EN
    logic err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p1 <= 1'b0;
        end else if (accept) begin
            err_p1 <= !is_legal_op(op_p0);
        end
    end

    assign bus.rsp_err = err_p1;
`else
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-cycle vector table plus hand-written
// reset and opcode-check sequences.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NR = 2;
    localparam int NV = 23;

`ifdef ALU_OPCODE_CHECK_EN
    localparam logic [31:0] E_ERR = 32'd1;
`else
    localparam logic [31:0] E_ERR = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op0;
        logic [1:0]  rr;
        logic [1:0]  e_rdy;
        logic [1:0]  e_rv;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: actual %h required %h", name, idx, act, exp);
        end
    endtask

    // Requester 1 always presents XOR F0^FF = 0F.
    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0, input logic [1:0] rr);
        bus.req_valid = v;
        bus.req_a     = {32'h0000_00F0, a0};
        bus.req_b     = {32'h0000_00FF, b0};
        bus.req_op    = {4'h3, op0};
        bus.rsp_ready = rr;
    endtask

    initial begin
        //            v      a0            b0     op0    rr     rdy    rv     result
        vecs[0]  = '{2'b01, 32'd5,        32'd3,  4'hB, 2'b11, 2'b01, 2'b00, 32'h0};
        vecs[1]  = '{2'b00, 32'd0,        32'd0,  4'h0, 2'b11, 2'b00, 2'b01, 32'h8};
        vecs[2]  = '{2'b10, 32'd0,        32'd0,  4'h0, 2'b11, 2'b10, 2'b00, 32'h0};
        vecs[3]  = '{2'b11, 32'h10,       32'h4,  4'hA, 2'b11, 2'b01, 2'b10, 32'h0F};
        vecs[4]  = '{2'b11, 32'h10,       32'h4,  4'hA, 2'b11, 2'b10, 2'b01, 32'h0C};
        vecs[5]  = '{2'b11, 32'h10,       32'h4,  4'hA, 2'b11, 2'b01, 2'b10, 32'h0F};
        vecs[6]  = '{2'b11, 32'h10,       32'h4,  4'hA, 2'b11, 2'b10, 2'b01, 32'h0C};
        vecs[7]  = '{2'b11, 32'h10,       32'h4,  4'hA, 2'b11, 2'b01, 2'b10, 32'h0F};
        vecs[8]  = '{2'b10, 32'h10,       32'h4,  4'hA, 2'b10, 2'b00, 2'b01, 32'h0C};
        vecs[9]  = '{2'b10, 32'h10,       32'h4,  4'hA, 2'b10, 2'b00, 2'b01, 32'h0C};
        vecs[10] = '{2'b10, 32'h10,       32'h4,  4'hA, 2'b10, 2'b00, 2'b01, 32'h0C};
        vecs[11] = '{2'b10, 32'h10,       32'h4,  4'hA, 2'b11, 2'b10, 2'b01, 32'h0C};
        vecs[12] = '{2'b00, 32'd0,        32'd0,  4'h0, 2'b11, 2'b00, 2'b10, 32'h0F};
        vecs[13] = '{2'b01, 32'hFFFFFFF8, 32'd2,  4'hD, 2'b11, 2'b01, 2'b00, 32'h0};
        vecs[14] = '{2'b01, 32'hFFFFFFFF, 32'd1,  4'hC, 2'b11, 2'b01, 2'b01, 32'hFFFFFFFE};
        vecs[15] = '{2'b01, 32'hFFFFFFFF, 32'd1,  4'h6, 2'b11, 2'b01, 2'b01, 32'h1};
        vecs[16] = '{2'b01, 32'd1,        32'd4,  4'h4, 2'b11, 2'b01, 2'b01, 32'h0};
        vecs[17] = '{2'b01, 32'h80000000, 32'd31, 4'h5, 2'b11, 2'b01, 2'b01, 32'h10};
        vecs[18] = '{2'b01, 32'd7,        32'd7,  4'h8, 2'b11, 2'b01, 2'b01, 32'h1};
        vecs[19] = '{2'b01, 32'd3,        32'd5,  4'hA, 2'b11, 2'b01, 2'b01, 32'h1};
        vecs[20] = '{2'b01, 32'd3,        32'd5,  4'h2, 2'b11, 2'b01, 2'b01, 32'hFFFFFFFE};
        vecs[21] = '{2'b00, 32'd0,        32'd0,  4'h0, 2'b11, 2'b00, 2'b01, 32'h0};
        vecs[22] = '{2'b00, 32'd0,        32'd0,  4'h0, 2'b11, 2'b00, 2'b00, 32'h0};

        // Reset: requests pending but nothing may be accepted.
        rst_n = 1'b0;
        drive(2'b11, 32'd5, 32'd3, 4'hB, 2'b11);
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 0, 32'(bus.req_ready), 32'h0);
        chk("reset_rsp_valid", 0, 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_result", 0, bus.rsp_result, 32'h0);
        chk("reset_rsp_err", 0, 32'(bus.rsp_err), 32'h0);
        drive(2'b00, 32'd0, 32'd0, 4'h0, 2'b11);
        rst_n = 1'b1;

        // Single op, contention, backpressure, signed and misc ops.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].v, vecs[i].a0, vecs[i].b0, vecs[i].op0, vecs[i].rr);
            @(negedge clk);
            chk("req_ready", i, 32'(bus.req_ready), 32'(vecs[i].e_rdy));
            chk("rsp_valid", i, 32'(bus.rsp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv != 2'b00)
                chk("rsp_result", i, bus.rsp_result, vecs[i].e_res);
        end

        // Reset while FULL: slot drops asynchronously, pointer back to 0.
        @(posedge clk);
        #1;
        drive(2'b01, 32'd1, 32'd1, 4'hB, 2'b00);
        @(negedge clk);
        chk("mid_req_ready", 0, 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        drive(2'b00, 32'd0, 32'd0, 4'h0, 2'b00);
        @(negedge clk);
        chk("mid_rsp_valid", 0, 32'(bus.rsp_valid), 32'h1);
        chk("mid_rsp_result", 0, bus.rsp_result, 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 0, 32'(bus.rsp_valid), 32'h0);
        chk("async_rsp_result", 0, bus.rsp_result, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(2'b11, 32'd2, 32'd2, 4'hB, 2'b11);
        @(negedge clk);
        chk("rearb_req_ready", 0, 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        drive(2'b00, 32'd0, 32'd0, 4'h0, 2'b11);
        @(negedge clk);
        chk("rearb_rsp_valid", 0, 32'(bus.rsp_valid), 32'h1);
        chk("rearb_rsp_result", 0, bus.rsp_result, 32'h4);

        // Illegal opcode followed by a legal one.
        @(posedge clk);
        #1;
        drive(2'b01, 32'd5, 32'd5, 4'hE, 2'b11);
        @(negedge clk);
        chk("ill_req_ready", 0, 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        drive(2'b01, 32'd5, 32'd5, 4'h0, 2'b11);
        @(negedge clk);
        chk("ill_rsp_valid", 0, 32'(bus.rsp_valid), 32'h1);
        chk("ill_rsp_result", 0, bus.rsp_result, 32'h0);
        chk("ill_rsp_err", 0, 32'(bus.rsp_err), E_ERR);
        @(posedge clk);
        #1;
        drive(2'b00, 32'd0, 32'd0, 4'h0, 2'b11);
        @(negedge clk);
        chk("legal_rsp_valid", 0, 32'(bus.rsp_valid), 32'h1);
        chk("legal_rsp_result", 0, bus.rsp_result, 32'h5);
        chk("legal_rsp_err", 0, 32'(bus.rsp_err), 32'h0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
